booth_r4_mult: RTL and testbench
================================

# booth_r4_mult

Parametrised sequential radix-4 (modified) Booth multiplier, the successor to the team's 8-bit radix-2 Booth block. It multiplies two WIDTH-bit operands, either signed or unsigned as chosen per operation, and returns an exact 2·WIDTH-bit product. It retires two multiplier bits per cycle using a start/busy/done handshake. It sits beside the datapath as a multi-cycle arithmetic unit and holds its result until the next accepted operation.

## Interface
- WIDTH, default 8: operand width. Must be even and ≥ 4.
- clk  input  1  rising-edge clock; the only clock.
- reset  input  1  synchronous, active-low reset; sampled on rising clk.
- start  input  1  request a new operation; sampled only when the block is idle.
- signed_mode  input  1  selects the operand type, captured with start: 1 = two's-complement, 0 = unsigned.
- a  input  WIDTH  multiplicand, captured with start.
- b  input  WIDTH  multiplier, captured with start.
- busy  output  1  high while an operation is in progress.
- done  output  1  one-cycle pulse marking a new product.
- product  output  2·WIDTH  result register; holds its value until the next done.

## Operation
- ITER = (WIDTH+2)/2 iterations per operation; for WIDTH=8, ITER=5.
- States:
  - IDLE:
    - start=1 captures a, b and signed_mode, clears the accumulator and the count, and moves to RUN.
    - start=0 stays in IDLE.
  - RUN: performs one iteration per cycle. After iteration ITER it writes product, pulses done and returns to IDLE.
- Operand extension:
  - Multiplicand is extended to WIDTH+1 bits, sign-extended if signed_mode=1 and zero-extended otherwise.
  - Multiplier is extended the same way to WIDTH+2 bits, with an implicit b[-1]=0 below bit 0.
- Recoding of the triple {b[2i+1], b[2i], b[2i−1]}:
  - 000 or 111 → +0
  - 001 or 010 → +A
  - 011 → +2A
  - 100 → −2A
  - 101 or 110 → −A
- Accumulator:
  - Upper part is WIDTH+3 bits so ±2A never overflows.
  - Each iteration adds the selected partial product to the upper part, then arithmetic-shifts the whole accumulator right by 2.
- Result: product equals a×b exactly, modulo 2^(2·WIDTH) in neither mode.
  - Signed range: [−2^(2W−2)+2^(W−1), 2^(2W−2)].
  - Unsigned maximum: (2^W−1)².
- Negation is two's-complement of the extended value. Negating the most negative value, −2^(WIDTH−1), is exact because of the extension bit.
- Inputs a, b and signed_mode are ignored outside the capture edge. Changing them during RUN has no effect on the result.

## Timing
- Reset (reset=0 at a rising edge) forces state=IDLE, busy=0, done=0, product=0, accumulator=0 and count=0.
- Reset mid-operation aborts the operation: no done pulse is produced and product reads 0.
- Start is captured at edge E0.
- busy is high from the cycle after E0 up to and including the cycle before done.
- At edge E0+ITER, product updates and done=1 for exactly one cycle; busy=0 in that same cycle.
- Latency from start capture to done high is ITER cycles; for WIDTH=8 this is 5.
- start while busy=1 is ignored; the operation is not queued.
- start=1 in the cycle done=1 is accepted, because the block is idle. This gives back-to-back throughput of one result per ITER+1 cycles.
- start held high continuously restarts the block after every done.
- product changes only on a done edge or on reset.

## Test plan
- Reset: hold reset=0 for 2 cycles, then release.
  - Required: busy=0, done=0, product=0.
  - start=0 for 10 cycles must leave all outputs unchanged.
- WIDTH=8, signed:
  - −128×−128 → 0x4000
  - −1×1 → 0xFFFF
  - 127×−128 → 0xC080
  - Each done pulse is exactly 5 cycles after start capture and 1 cycle wide.
- WIDTH=8, unsigned:
  - 255×255 → 0xFE01
  - 200×3 → 0x0258
  - 0×173 → 0x0000
  - Same operand bits with signed_mode=1: 0xFF×0xFF → 0x0001.
- Handshake:
  - Pulse start again at cycles 2 and 4 of a running operation; the pulses must be ignored and exactly one done produced.
  - Toggle a and b mid-RUN; product must be unchanged.
  - Assert start in the done cycle with 3×5; 15 must appear 6 cycles after the first done.
- Reset mid-operation: assert reset=0 at the third RUN cycle.
  - Required: busy=0 and product=0 next cycle, and no done.
  - A subsequent 7×−6 (signed) must give 0xFFD6.
- WIDTH=16 (ITER=9):
  - Signed −32768×−32768 → 0x40000000.
  - Unsigned 65535×65535 → 0xFFFE0001.
  - Random sweep of 1000 operands in both modes, checked against a behavioural reference multiplier.

Source files
------------

// File: rtl/booth_r4_mult.sv
// Sequential radix-4 (modified) Booth multiplier: signed or unsigned WIDTH x WIDTH operands,
// exact 2*WIDTH product, two multiplier bits retired per cycle under a start/busy/done handshake.
module booth_r4_mult #(
    parameter int unsigned WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 signed_mode,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    localparam int unsigned ITER = (WIDTH + 2) / 2;
    localparam int unsigned CW   = $clog2(ITER);
    localparam int unsigned HW   = WIDTH + 3;   // upper part: room for +/-2A
    localparam int unsigned LW   = WIDTH + 2;   // lower part: extended multiplier
    localparam int unsigned AW   = HW + LW;

    typedef enum logic {IDLE, RUN} state_t;

    state_t          state, state_nxt;
    logic [WIDTH:0]  mcand;
    logic [AW-1:0]   acc, acc_nxt;
    logic            q_m1;
    logic [CW-1:0]   count;
    logic            last;
    logic [HW-1:0]   pp, sum;

    assign busy = (state == RUN);

    always_ff @(posedge clk) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        last      = (state == RUN) && (count == CW'(ITER - 1));
        case (state)
            IDLE:    if (start) state_nxt = RUN;
            RUN:     if (last)  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Recode {b[2i+1], b[2i], b[2i-1]}; low two accumulator bits hold the current pair
    always_comb begin
        pp = '0;
        case ({acc[1:0], q_m1})
            3'b001, 3'b010: pp = {{2{mcand[WIDTH]}}, mcand};
            3'b011:         pp = {mcand[WIDTH], mcand, 1'b0};
            3'b100:         pp = -{mcand[WIDTH], mcand, 1'b0};
            3'b101, 3'b110: pp = -{{2{mcand[WIDTH]}}, mcand};
            default:        pp = '0;
        endcase
        sum     = acc[AW-1:LW] + pp;
        acc_nxt = {{2{sum[HW-1]}}, sum, acc[LW-1:2]};
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            mcand   <= '0;
            acc     <= '0;
            q_m1    <= 1'b0;
            count   <= '0;
            done    <= 1'b0;
            product <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        mcand <= {signed_mode & a[WIDTH-1], a};
                        acc   <= AW'({{2{signed_mode & b[WIDTH-1]}}, b});
                        q_m1  <= 1'b0;
                        count <= '0;
                    end
                end
                RUN: begin
                    acc   <= acc_nxt;
                    q_m1  <= acc[1];
                    count <= count + CW'(1);
                    if (last) begin
                        product <= acc_nxt[2*WIDTH-1:0];
                        done    <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_booth_r4_mult.sv
// Directed and randomised checks of booth_r4_mult at WIDTH=8 and WIDTH=16.
module tb_booth_r4_mult;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;

    logic        start8 = 1'b0, sm8 = 1'b0;
    logic [7:0]  a8 = '0, b8 = '0;
    logic        busy8, done8;
    logic [15:0] p8;

    logic        start16 = 1'b0, sm16 = 1'b0;
    logic [15:0] a16 = '0, b16 = '0;
    logic        busy16, done16;
    logic [31:0] p16;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    booth_r4_mult #(.WIDTH(8)) dut8 (
        .clk(clk), .reset(rst_n), .start(start8), .signed_mode(sm8),
        .a(a8), .b(b8), .busy(busy8), .done(done8), .product(p8)
    );

    booth_r4_mult #(.WIDTH(16)) dut16 (
        .clk(clk), .reset(rst_n), .start(start16), .signed_mode(sm16),
        .a(a16), .b(b16), .busy(busy16), .done(done16), .product(p16)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic op8(input string tag, input logic sm, input logic [7:0] aa, input logic [7:0] bb,
                       input logic [15:0] exp);
        int lat = 0;
        tick();
        start8 = 1'b1; sm8 = sm; a8 = aa; b8 = bb;
        tick();
        start8 = 1'b0;
        check({tag, "_busy"}, 64'(busy8), 64'd1);
        while (!done8 && lat < 20) begin
            tick();
            lat++;
        end
        check({tag, "_lat"}, 64'(lat), 64'd5);
        check({tag, "_prod"}, 64'(p8), 64'(exp));
        check({tag, "_busy_at_done"}, 64'(busy8), 64'd0);
        tick();
        check({tag, "_done_width"}, 64'(done8), 64'd0);
    endtask

    task automatic op16(input string tag, input logic sm, input logic [15:0] aa, input logic [15:0] bb,
                        input logic [31:0] exp, input bit verbose);
        int lat = 0;
        tick();
        start16 = 1'b1; sm16 = sm; a16 = aa; b16 = bb;
        tick();
        start16 = 1'b0;
        while (!done16 && lat < 30) begin
            tick();
            lat++;
        end
        if (verbose) check({tag, "_lat"}, 64'(lat), 64'd9);
        check({tag, "_prod"}, 64'(p16), 64'(exp));
    endtask

    initial begin
        int lat;
        int ndone;
        logic [15:0] cap;
        logic [15:0] ra, rb;
        logic        rs;
        longint      ea, eb, ep;

        // Reset for two cycles
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        check("rst_busy", 64'(busy8), 64'd0);
        check("rst_done", 64'(done8), 64'd0);
        check("rst_prod", 64'(p8), 64'd0);
        check("rst_busy16", 64'(busy16), 64'd0);
        check("rst_prod16", 64'(p16), 64'd0);
        for (int i = 0; i < 10; i++) begin
            tick();
            check("idle_outputs", {47'd0, busy8, done8, p8}, 64'd0);
        end

        // WIDTH=8 signed
        op8("s_m128xm128", 1'b1, 8'h80, 8'h80, 16'h4000);
        op8("s_m1x1",      1'b1, 8'hFF, 8'h01, 16'hFFFF);
        op8("s_127xm128",  1'b1, 8'h7F, 8'h80, 16'hC080);
        // WIDTH=8 unsigned
        op8("u_255x255",   1'b0, 8'hFF, 8'hFF, 16'hFE01);
        op8("u_200x3",     1'b0, 8'd200, 8'd3, 16'h0258);
        op8("u_0x173",     1'b0, 8'd0, 8'd173, 16'h0000);
        op8("s_ffxff",     1'b1, 8'hFF, 8'hFF, 16'h0001);

        // Start pulses and operand changes during RUN are ignored
        tick();
        start8 = 1'b1; sm8 = 1'b0; a8 = 8'd10; b8 = 8'd11;
        tick();
        start8 = 1'b0;
        tick();
        start8 = 1'b1; a8 = 8'd99; b8 = 8'd77;
        tick();
        start8 = 1'b0; a8 = 8'd3; b8 = 8'd200;
        tick();
        start8 = 1'b1; sm8 = 1'b1; a8 = 8'hFF;
        tick();
        start8 = 1'b0;
        ndone = 0;
        cap = '0;
        for (int i = 0; i < 14; i++) begin
            if (done8) begin
                ndone++;
                cap = p8;
            end
            tick();
        end
        check("hs_done_count", 64'(ndone), 64'd1);
        check("hs_prod", 64'(cap), 64'h006E);

        // Back-to-back: start held, new operands accepted in the done cycle
        sm8 = 1'b0; a8 = 8'd4; b8 = 8'd4; start8 = 1'b1;
        lat = 0;
        tick();
        while (!done8 && lat < 20) begin
            tick();
            lat++;
        end
        check("b2b_first_prod", 64'(p8), 64'd16);
        a8 = 8'd3; b8 = 8'd5;
        tick();
        start8 = 1'b0;
        lat = 1;
        check("b2b_busy_restart", 64'(busy8), 64'd1);
        while (!done8 && lat < 20) begin
            tick();
            lat++;
        end
        check("b2b_gap", 64'(lat), 64'd6);
        check("b2b_prod", 64'(p8), 64'd15);

        // Reset in the third RUN cycle aborts
        tick();
        start8 = 1'b1; sm8 = 1'b0; a8 = 8'd100; b8 = 8'd100;
        tick();
        start8 = 1'b0;
        tick();
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("abort_busy", 64'(busy8), 64'd0);
        check("abort_prod", 64'(p8), 64'd0);
        ndone = 0;
        for (int i = 0; i < 8; i++) begin
            if (done8) ndone++;
            tick();
        end
        check("abort_no_done", 64'(ndone), 64'd0);
        check("abort_prod_held", 64'(p8), 64'd0);
        op8("s_7xm6", 1'b1, 8'd7, 8'hFA, 16'hFFD6);

        // WIDTH=16
        op16("w16_s_min", 1'b1, 16'h8000, 16'h8000, 32'h4000_0000, 1'b1);
        op16("w16_u_max", 1'b0, 16'hFFFF, 16'hFFFF, 32'hFFFE_0001, 1'b1);
        for (int i = 0; i < 1000; i++) begin
            ra = 16'($urandom);
            rb = 16'($urandom);
            rs = 1'($urandom);
            if (rs) begin
                ea = longint'($signed(ra));
                eb = longint'($signed(rb));
            end else begin
                ea = longint'(ra);
                eb = longint'(rb);
            end
            ep = ea * eb;
            op16(rs ? "w16_rand_s" : "w16_rand_u", rs, ra, rb, ep[31:0], 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
